alu_exec_stage: RTL and testbench

Registered execute stage that feeds the ALU result path. It accepts decoded operand pairs from issue, computes the selected ALU function, and presents the result to writeback. The function set is add, sub, logic, sll, srl and sra; sra uses the same semantics as the alu_sra unit. Both sides use a valid/ready handshake. A one-entry skid buffer keeps in_ready a registered signal.

---
 rtl/alu_exec_stage_if.sv | 28 ++
 rtl/alu_exec_stage.sv | 130 +++++++++++++
 tb/tb_alu_exec_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Issue-side and writeback-side handshake bundle for alu_exec_stage.
// The stage uses the slave view; the issue/writeback agent uses the master view.
interface alu_exec_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [RA_W-1:0] rd_addr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;
  logic [RA_W-1:0] rd_addr_out;
  logic            illegal;

  modport master (
    output in_valid, op, rs1, rs2, rd_addr, out_ready,
    input  in_ready, out_valid, rd, rd_addr_out, illegal
  );

  modport slave (
    input  in_valid, op, rs1, rs2, rd_addr, out_ready,
    output in_ready, out_valid, rd, rd_addr_out, illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage, 1-cycle latency; OUT + SKID registers keep in_ready a flop (low only when both full).
// Define ALU_SLT_EN to add SLT/SLTU (ops 8/9); otherwise they return illegal.
module alu_exec_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  alu_exec_stage_if.slave  bus
);
  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
`ifdef ALU_SLT_EN
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
`endif

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic [RA_W-1:0] tag;
    logic            illegal;
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state, state_nxt;
  res_t            alu_res, out_q, skid_q;
  logic [SH_W-1:0] shamt;
  logic            in_ready_q, out_valid_q;
  logic            accept, load_out, load_skid, drain_skid;

  // Only the low bits of rs2 form the shift amount; upper bits are ignored.
  assign shamt = bus.rs2[SH_W-1:0];

  always_comb begin
    alu_res         = '0;
    alu_res.tag     = bus.rd_addr;
    case (bus.op)
      OP_ADD:  alu_res.rd = bus.rs1 + bus.rs2;
      OP_SUB:  alu_res.rd = bus.rs1 - bus.rs2;
      OP_AND:  alu_res.rd = bus.rs1 & bus.rs2;
      OP_OR:   alu_res.rd = bus.rs1 | bus.rs2;
      OP_XOR:  alu_res.rd = bus.rs1 ^ bus.rs2;
      OP_SLL:  alu_res.rd = bus.rs1 << shamt;
      OP_SRL:  alu_res.rd = bus.rs1 >> shamt;
      OP_SRA:  alu_res.rd = $unsigned($signed(bus.rs1) >>> shamt);
`ifdef ALU_SLT_EN
      OP_SLT:  alu_res.rd = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
      OP_SLTU: alu_res.rd = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.rs2)};
`endif
      default: alu_res.illegal = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  always_comb begin
    state_nxt  = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    drain_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        if (accept && bus.out_ready) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (bus.out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          state_nxt  = ONE;
          drain_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out) begin
        out_q <= alu_res;
      end else if (drain_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= alu_res;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.rd          = out_q.rd;
  assign bus.rd_addr_out = out_q.tag;
  assign bus.illegal     = out_q.illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes expected results, negedge monitor pops and compares.
module tb_alu_exec_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();
  alu_exec_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  tag;
    logic        ill;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: transfers are judged at the negedge before the edge that completes them.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_rd;
  logic [4:0]  prev_tag;
  logic        prev_ill;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.out_valid) begin
        chk("hold_rd", bus.rd, prev_rd);
        chk("hold_tag", {27'd0, bus.rd_addr_out}, {27'd0, prev_tag});
        chk("hold_illegal", {31'd0, bus.illegal}, {31'd0, prev_ill});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_rd    = bus.rd;
      prev_tag   = bus.rd_addr_out;
      prev_ill   = bus.illegal;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out actual tag=%0d rd=0x%08h required=no output", bus.rd_addr_out, bus.rd);
        end else begin
          e = sb.pop_front();
          chk("rd", bus.rd, e.rd);
          chk("tag", {27'd0, bus.rd_addr_out}, {27'd0, e.tag});
          chk("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
          if (e.lat) chk("latency_cycle", cyc, e.acc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] erd, input logic eill, input bit lat);
    int  n = 0;
    bit  done = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.rd_addr  = tag;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{erd, tag, eill, lat, cyc + 1});
        done = 1;
      end else if (++n >= 50) begin
        checks++;
        failures++;
        $display("FAIL issue_timeout tag=%0d actual in_ready=0 required=1 within 50 cycles", tag);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic slt_ill;
  logic [31:0] slt_rd, sltu_rd;

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.rd_addr   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_rd", bus.rd, 32'd0);
    chk("rst_rd_addr_out", {27'd0, bus.rd_addr_out}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    @(posedge clk); #1;

    // SRA sweep, back to back
    issue(4'd7, 32'd1431655765, 32'd1,  5'd10, 32'd715827882, 1'b0, 1);
    issue(4'd7, 32'd1431655765, 32'd10, 5'd11, 32'd1398101,   1'b0, 1);
    issue(4'd7, 32'd1431655765, 32'd72, 5'd12, 32'd5592405,   1'b0, 1);
    issue(4'd7, 32'h80000000,   32'd3,  5'd13, 32'hF0000000,  1'b0, 1);
    issue(4'd7, 32'd1,          32'd1,  5'd14, 32'd0,         1'b0, 1);
    wait_drain();

    // mixed ops, tags 1..5
    issue(4'd0, 32'hFFFFFFFF, 32'd1,        5'd1, 32'd0,        1'b0, 1);
    issue(4'd1, 32'd0,        32'd1,        5'd2, 32'hFFFFFFFF, 1'b0, 1);
    issue(4'd5, 32'd1,        32'd33,       5'd3, 32'd2,        1'b0, 1);
    issue(4'd6, 32'h80000000, 32'd31,       5'd4, 32'd1,        1'b0, 1);
    issue(4'd4, 32'hF0F0F0F0, 32'hFFFFFFFF, 5'd5, 32'h0F0F0F0F, 1'b0, 1);

    // illegal op followed by a legal one
    issue(4'd12, 32'd5, 32'd6, 5'd15, 32'd0,  1'b1, 1);
    issue(4'd0,  32'd5, 32'd6, 5'd16, 32'd11, 1'b0, 1);

`ifdef ALU_SLT_EN
    slt_ill = 1'b0; slt_rd = 32'd1; sltu_rd = 32'd0;
`else
    slt_ill = 1'b1; slt_rd = 32'd0; sltu_rd = 32'd0;
`endif
    issue(4'd8, 32'hFFFFFFFF, 32'd1, 5'd17, slt_rd,  slt_ill, 1);
    issue(4'd9, 32'hFFFFFFFF, 32'd1, 5'd18, sltu_rd, slt_ill, 1);
    wait_drain();

    // backpressure: fill OUT and SKID, third op must wait
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd7,    32'd1,    5'd7, 32'd8,    1'b0, 0);
    issue(4'd3, 32'hF0,   32'h0F,   5'd8, 32'hFF,   1'b0, 0);
    @(negedge clk);
    chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    fork
      issue(4'd2, 32'hFF, 32'h3C, 5'd9, 32'h3C, 1'b0, 0);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_first_drain", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
      end
    join
    wait_drain();

    // reset while FULL, with issue asserting in_valid during reset
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd1, 5'd20, 32'd2, 1'b0, 0);
    issue(4'd0, 32'd2, 32'd2, 5'd21, 32'd4, 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.op       = 4'd0;
    bus.rs1      = 32'd9;
    bus.rs2      = 32'd9;
    bus.rd_addr  = 5'd30;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_rd", bus.rd, 32'd0);
    @(posedge clk); #1;
    issue(4'd0, 32'd2, 32'd3, 5'd22, 32'd5, 1'b0, 1);
    wait_drain();
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
